// File: rtl/fifo_write_arbiter_if.sv
// Producer request bundle and FIFO write port
// shared by the write arbiter and its neighbours.
interface fifo_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        grant;
  logic                    full;
  logic                    w_en;
  logic [DATA_W-1:0]       w_data;

  modport master (
    input  req, req_data, req_last, full,
    output ack, grant, w_en, w_data
  );

  modport slave (
    output req, req_data, req_last, full,
    input  ack, grant, w_en, w_data
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for the async FIFO:
// one producer owns the port for a bounded burst.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic                  w_clk,
  input logic                  w_reset,
  fifo_write_arbiter_if.master bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic             w_req_g;
  logic             w_last_g;
  logic             w_take;

  // search starts just above the previous owner
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!w_any &&
          bus.req[IDX_W'((int'(r_last) + i) % N_REQ)]) begin
        w_any = 1'b1;
        w_win = IDX_W'((int'(r_last) + i) % N_REQ);
      end
    end
  end

  assign w_req_g  = bus.req[r_last];
  assign w_last_g = bus.req_last[r_last];
  assign bus.grant = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    bus.w_en    = 1'b0;
    bus.ack     = '0;
    bus.w_data  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt        = BURST;
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_last_nxt         = w_win;
          w_cnt_nxt          = '0;
        end
      end
      BURST: begin
        w_take      = w_req_g & ~bus.full;
        bus.w_en    = w_take;
        bus.w_data  = bus.req_data[r_last*DATA_W +: DATA_W];
        bus.ack[r_last] = w_take;
        // a dropped request ends the burst even while stalled
        if (!w_req_g ||
            (w_take && (w_last_g || r_cnt == CNT_END))) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (w_take) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_reset) begin
    if (!w_reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed
// producer traffic, expected writes and grants queued.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  fifo_write_arbiter #(
    .N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .w_clk(clk),
    .w_reset(rst_n),
    .bus(bus)
  );

  typedef struct { logic [DW-1:0] d; bit l; } word_t;
  typedef struct { int idx; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [N-1:0] g; int n; } gr_t;

  word_t pq [N][$];
  wr_t   exp_w [$];
  gr_t   exp_g [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        bus.req[i] = 1'b1;
        bus.req_data[i*DW +: DW] = pq[i][0].d;
        bus.req_last[i] = pq[i][0].l;
      end else begin
        bus.req[i] = 1'b0;
        bus.req_data[i*DW +: DW] = '0;
        bus.req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] a;
    @(negedge clk);
    a = bus.ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (a[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    drive();
  endtask

  function automatic bit all_done();
    bit e;
    e = (exp_w.size() == 0) && (exp_g.size() == 0)
        && (bus.grant == '0);
    for (int i = 0; i < N; i++)
      if (pq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      if (all_done()) break;
      tick();
    end
    if (k == 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got busy expected idle", nm);
    end
  endtask

  task automatic push_w(input int i, input logic [DW-1:0] d, input bit l);
    pq[i].push_back('{d: d, l: l});
    exp_w.push_back('{idx: i, d: d});
  endtask

  // monitor: compares every write and grant against the queues
  initial begin
    logic [N-1:0] prev_g;
    int wcnt;
    int wexp;
    wr_t e;
    gr_t ge;
    prev_g = '0;
    wcnt = 0;
    wexp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_g = '0;
        wcnt = 0;
      end else begin
        if (prev_g == '0 && bus.grant != '0) begin
          if (exp_g.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_unexpected: got %0b expected none",
                     bus.grant);
          end else begin
            ge = exp_g.pop_front();
            check("grant", 32'(bus.grant), 32'(ge.g));
            wexp = ge.n;
          end
          wcnt = 0;
        end else if (prev_g != '0 && bus.grant == '0) begin
          check("burst_len", wcnt, wexp);
        end else if (prev_g != '0 && bus.grant != prev_g) begin
          check("grant_hold", 32'(bus.grant), 32'(prev_g));
        end
        if (bus.w_en) begin
          check("w_en_vs_full", 32'(bus.full), 0);
          if (exp_w.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL write_unexpected: got %0h expected none",
                     bus.w_data);
          end else begin
            e = exp_w.pop_front();
            check("w_data", 32'(bus.w_data), 32'(e.d));
            check("ack", 32'(bus.ack), 32'(1) << e.idx);
          end
          wcnt++;
        end else begin
          check("ack_idle", 32'(bus.ack), 0);
        end
        prev_g = bus.grant;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.full = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_w_en", 32'(bus.w_en), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_w_data", 32'(bus.w_data), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_grant", 32'(bus.grant), 0);
      check("idle_w_en", 32'(bus.w_en), 0);
    end

    // round robin, full-length bursts
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < 4; j++)
          push_w(i, 8'(i*16 + r*4 + j), 1'b0);
        exp_g.push_back('{g: 4'(1 << i), n: 4});
      end
    drive();
    drain("round_robin");

    // early last on the 2nd word, then one more burst
    push_w(2, 8'hA1, 1'b0);
    push_w(2, 8'hA2, 1'b1);
    push_w(2, 8'hA3, 1'b1);
    exp_g.push_back('{g: 4'b0100, n: 2});
    exp_g.push_back('{g: 4'b0100, n: 1});
    drive();
    drain("early_last");

    push_w(0, 8'hB0, 1'b1);
    push_w(2, 8'hB2, 1'b1);
    exp_g.push_back('{g: 4'b0001, n: 1});
    exp_g.push_back('{g: 4'b0100, n: 1});
    drive();
    drain("after_last");

    // full stall after the first word
    for (int j = 0; j < 4; j++) push_w(1, 8'(8'hC1 + j), 1'b0);
    exp_g.push_back('{g: 4'b0010, n: 4});
    drive();
    tick();
    tick();
    bus.full = 1'b1;
    repeat (3) begin
      #1;
      check("stall_w_en", 32'(bus.w_en), 0);
      check("stall_ack", 32'(bus.ack), 0);
      check("stall_grant", 32'(bus.grant), 32'b0010);
      tick();
    end
    bus.full = 1'b0;
    drain("full_stall");

    // request drop after one word
    push_w(3, 8'hD1, 1'b0);
    exp_g.push_back('{g: 4'b1000, n: 1});
    drive();
    drain("req_drop");

    push_w(0, 8'hE0, 1'b1);
    push_w(1, 8'hE1, 1'b1);
    push_w(2, 8'hE2, 1'b1);
    exp_g.push_back('{g: 4'b0001, n: 1});
    exp_g.push_back('{g: 4'b0010, n: 1});
    exp_g.push_back('{g: 4'b0100, n: 1});
    drive();
    drain("after_drop");

    // asynchronous reset during the 3rd word
    pq[1].push_back('{d: 8'hF1, l: 1'b0});
    pq[1].push_back('{d: 8'hF2, l: 1'b0});
    pq[1].push_back('{d: 8'hF3, l: 1'b0});
    pq[1].push_back('{d: 8'hF4, l: 1'b0});
    exp_w.push_back('{idx: 1, d: 8'hF1});
    exp_w.push_back('{idx: 1, d: 8'hF2});
    exp_g.push_back('{g: 4'b0010, n: 4});
    drive();
    tick();
    tick();
    tick();
    check("pre_rst_w_en", 32'(bus.w_en), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_w_en", 32'(bus.w_en), 0);
    check("mid_rst_ack", 32'(bus.ack), 0);
    check("mid_rst_grant", 32'(bus.grant), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    push_w(0, 8'h90, 1'b1);
    exp_w.push_back('{idx: 1, d: 8'hF3});
    exp_w.push_back('{idx: 1, d: 8'hF4});
    exp_g.push_back('{g: 4'b0001, n: 1});
    exp_g.push_back('{g: 4'b0010, n: 2});
    drive();
    drain("after_reset");

    repeat (2) tick();
    check("leftover_writes", exp_w.size(), 0);
    check("leftover_grants", exp_g.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
